// File: rtl/hilo_muldiv_unit.sv
// HI/LO execution unit: single-cycle MFHI/MFLO/MTHI/MTLO plus iterative
// radix-2 MULT/MULTU/DIV/DIVU that stall the pipeline while running.
`ifndef FUNCT_MFHI
`define FUNCT_MFHI  6'b010000
`endif
`ifndef FUNCT_MTHI
`define FUNCT_MTHI  6'b010001
`endif
`ifndef FUNCT_MFLO
`define FUNCT_MFLO  6'b010010
`endif
`ifndef FUNCT_MTLO
`define FUNCT_MTLO  6'b010011
`endif
`ifndef FUNCT_MULT
`define FUNCT_MULT  6'b011000
`endif
`ifndef FUNCT_MULTU
`define FUNCT_MULTU 6'b011001
`endif
`ifndef FUNCT_DIV
`define FUNCT_DIV   6'b011010
`endif
`ifndef FUNCT_DIVU
`define FUNCT_DIVU  6'b011011
`endif

module hilo_muldiv_unit #(
  parameter int DATA_W  = 32,
  parameter int FUNCT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               op_valid,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [DATA_W-1:0]  operand_1,
  input  logic [DATA_W-1:0]  operand_2,
  input  logic               flush,
  output logic [DATA_W-1:0]  result,
  output logic               stall,
  output logic [DATA_W-1:0]  hi_out,
  output logic [DATA_W-1:0]  lo_out
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [FUNCT_W-1:0] F_MFHI  = FUNCT_W'(`FUNCT_MFHI);
  localparam logic [FUNCT_W-1:0] F_MTHI  = FUNCT_W'(`FUNCT_MTHI);
  localparam logic [FUNCT_W-1:0] F_MFLO  = FUNCT_W'(`FUNCT_MFLO);
  localparam logic [FUNCT_W-1:0] F_MTLO  = FUNCT_W'(`FUNCT_MTLO);
  localparam logic [FUNCT_W-1:0] F_MULT  = FUNCT_W'(`FUNCT_MULT);
  localparam logic [FUNCT_W-1:0] F_MULTU = FUNCT_W'(`FUNCT_MULTU);
  localparam logic [FUNCT_W-1:0] F_DIV   = FUNCT_W'(`FUNCT_DIV);
  localparam logic [FUNCT_W-1:0] F_DIVU  = FUNCT_W'(`FUNCT_DIVU);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t                state_q, state_d;
  logic [DATA_W-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2*DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]     opnd_q, opnd_d;
  logic [DATA_W-1:0]     op1_raw_q, op1_raw_d;
  logic                  is_div_q, is_div_d;
  logic                  neg_q, neg_d;
  logic                  neg_rem_q, neg_rem_d;
  logic                  div_zero_q, div_zero_d;

  logic                  is_mul, is_div, is_signed, start;
  logic [DATA_W-1:0]     mag_1, mag_2;
  logic [DATA_W:0]       mul_sum, rem_sh, rem_diff;
  logic [2*DATA_W-1:0]   prod_fix;
  logic [DATA_W-1:0]     quo_fix, rem_fix;

  assign is_mul    = (funct == F_MULT) || (funct == F_MULTU);
  assign is_div    = (funct == F_DIV)  || (funct == F_DIVU);
  assign is_signed = (funct == F_MULT) || (funct == F_DIV);
  assign start     = op_valid && !flush && (state_q == IDLE) && (is_mul || is_div);

  assign mag_1 = (is_signed && operand_1[DATA_W-1]) ? -operand_1 : operand_1;
  assign mag_2 = (is_signed && operand_2[DATA_W-1]) ? -operand_2 : operand_2;

  // Multiply step: add multiplicand into the upper half on LSB, shift right.
  assign mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
  // Divide step: shift remainder/dividend left, trial-subtract the divisor.
  assign rem_sh   = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
  assign rem_diff = rem_sh - {1'b0, opnd_q};

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo_fix  = neg_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
  assign rem_fix  = neg_rem_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    op1_raw_d  = op1_raw_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    result     = '0;
    stall      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (op_valid && funct == F_MFHI) result = hi_q;
        if (op_valid && funct == F_MFLO) result = lo_q;
        if (op_valid && !flush && funct == F_MTHI) hi_d = operand_1;
        if (op_valid && !flush && funct == F_MTLO) lo_d = operand_1;
        if (start) begin
          stall      = 1'b1;
          state_d    = CALC;
          cnt_d      = '0;
          is_div_d   = is_div;
          opnd_d     = is_div ? mag_2 : mag_1;
          acc_d      = {{DATA_W{1'b0}}, (is_div ? mag_1 : mag_2)};
          op1_raw_d  = operand_1;
          neg_d      = is_signed && (operand_1[DATA_W-1] ^ operand_2[DATA_W-1]);
          neg_rem_d  = is_signed && operand_1[DATA_W-1];
          div_zero_d = (operand_2 == '0);
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (is_div_q) begin
            acc_d = rem_diff[DATA_W]
                  ? {rem_sh[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0}
                  : {rem_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
          end else begin
            acc_d = {mul_sum, acc_q[DATA_W-1:1]};
          end
          if (cnt_q == CNT_W'(DATA_W - 1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!flush) begin
          if (!is_div_q) begin
            {hi_d, lo_d} = prod_fix;
          end else if (div_zero_q) begin
            hi_d = op1_raw_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      op1_raw_q  <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      op1_raw_q  <= op1_raw_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed self-checking bench for hilo_muldiv_unit with hand-computed results.
module tb_hilo_muldiv_unit;

  localparam int DATA_W  = 32;
  localparam int FUNCT_W = 6;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              op_valid = 1'b0;
  logic [5:0]        funct = '0;
  logic [31:0]       operand_1 = '0;
  logic [31:0]       operand_2 = '0;
  logic              flush = 1'b0;
  logic [31:0]       result, hi_out, lo_out;
  logic              stall;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  hilo_muldiv_unit #(.DATA_W(DATA_W), .FUNCT_W(FUNCT_W)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .funct(funct),
    .operand_1(operand_1), .operand_2(operand_2), .flush(flush),
    .result(result), .stall(stall), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle MTHI/MTLO issue; stall must stay low.
  task automatic move_to(input logic [5:0] f, input logic [31:0] v, input string tag);
    op_valid = 1'b1; funct = f; operand_1 = v; #1;
    check_eq({tag, "_stall"}, {63'd0, stall}, 64'd0);
    tick();
    op_valid = 1'b0;
  endtask

  // Holds the instruction while stalled, also through the FIX cycle.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string tag);
    int unsigned n_stall = 0;
    op_valid = 1'b1; funct = f; operand_1 = a; operand_2 = b; #1;
    while (stall && n_stall < 100) begin
      n_stall++;
      tick();
    end
    check_eq({tag, "_stall_len"}, 64'(n_stall), 64'd33);
    tick();
    op_valid = 1'b0; #1;
    check_eq({tag, "_hi"}, {32'd0, hi_out}, {32'd0, exp_hi});
    check_eq({tag, "_lo"}, {32'd0, lo_out}, {32'd0, exp_lo});
    check_eq({tag, "_idle_stall"}, {63'd0, stall}, 64'd0);
  endtask

  initial begin
    #3;
    check_eq("rst_hi", {32'd0, hi_out}, 64'd0);
    check_eq("rst_lo", {32'd0, lo_out}, 64'd0);
    check_eq("rst_stall", {63'd0, stall}, 64'd0);
    check_eq("rst_result", {32'd0, result}, 64'd0);
    #10 rst_n = 1'b1;
    tick();

    move_to(F_MTHI, 32'hDEADBEEF, "mthi");
    op_valid = 1'b1; funct = F_MFHI; #1;
    check_eq("mfhi", {32'd0, result}, 64'hDEADBEEF);
    check_eq("mfhi_stall", {63'd0, stall}, 64'd0);
    check_eq("mthi_lo_kept", {32'd0, lo_out}, 64'd0);
    op_valid = 1'b0; #1;
    check_eq("result_no_valid", {32'd0, result}, 64'd0);
    op_valid = 1'b1; funct = 6'b000000; #1;
    check_eq("unknown_stall", {63'd0, stall}, 64'd0);
    check_eq("unknown_result", {32'd0, result}, 64'd0);
    tick();
    op_valid = 1'b0;

    run_op(F_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, "mult");
    run_op(F_MULTU, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, "multu");
    run_op(F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
    run_op(F_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_negdiv");
    run_op(F_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, "divu");
    run_op(F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf");
    run_op(F_DIVU,  32'h12345678, 32'h0,        32'h12345678, 32'hFFFFFFFF, "divu_zero");
    run_op(F_DIV,   32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 32'hFFFFFFFF, "div_zero");

    op_valid = 1'b1; funct = F_MFLO; #1;
    check_eq("mflo", {32'd0, result}, 64'hFFFFFFFF);
    op_valid = 1'b0;
    tick();

    // Flush in the 10th CALC cycle.
    move_to(F_MTHI, 32'h11, "pre_hi");
    move_to(F_MTLO, 32'h22, "pre_lo");
    op_valid = 1'b1; funct = F_MULT; operand_1 = 32'd5; operand_2 = 32'd9;
    tick();
    for (int i = 1; i < 10; i++) tick();
    flush = 1'b1; #1;
    check_eq("flush_stall", {63'd0, stall}, 64'd0);
    tick();
    flush = 1'b0; funct = F_MFHI; #1;
    check_eq("flush_idle_mfhi", {32'd0, result}, 64'h11);
    check_eq("flush_hi", {32'd0, hi_out}, 64'h11);
    check_eq("flush_lo", {32'd0, lo_out}, 64'h22);
    op_valid = 1'b0;
    tick();

    op_valid = 1'b1; funct = F_MTLO; operand_1 = 32'h5555; flush = 1'b1;
    tick();
    op_valid = 1'b0; flush = 1'b0; #1;
    check_eq("mtlo_flushed", {32'd0, lo_out}, 64'h22);

    // Asynchronous reset mid-CALC.
    op_valid = 1'b1; funct = F_MULT; operand_1 = 32'd3; operand_2 = 32'd4;
    for (int i = 0; i < 6; i++) tick();
    #2 rst_n = 1'b0; op_valid = 1'b0; #1;
    check_eq("arst_stall", {63'd0, stall}, 64'd0);
    check_eq("arst_hi", {32'd0, hi_out}, 64'd0);
    check_eq("arst_lo", {32'd0, lo_out}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op(F_MULT, 32'd7, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
